sipo_deser_param: RTL and testbench
===================================

// Module: sipo_deser_param
// PURPOSE
//  Parametrised serial-in/parallel-out deserializer. Collects WIDTH serial bits into one word.
//  Selectable bit order. Partial words survive input gaps. Output uses a valid/ready handshake
//  with backpressure. Sits between a 1-bit serial source and a word-wide consumer.
// PARAMETERS
//  WIDTH      4  bits per output word; WIDTH >= 2.
//  LSB_FIRST  0  0: first bit received lands in p_out[WIDTH-1]. 1: first bit lands in p_out[0].
//  CNT_W      $clog2(WIDTH+1)  width of bit_cnt (derived; do not override).
// PORTS
//  clk        in   1      clock, rising edge.
//  rst_n      in   1      asynchronous active-low reset.
//  in_valid   in   1      s_in carries a valid bit this cycle.
//  s_in       in   1      serial data bit.
//  in_ready   out  1      block can accept a bit this cycle.
//  clear      in   1      synchronous flush of the partial word.
//  out_valid  out  1      p_out holds a complete word.
//  out_ready  in   1      consumer accepts p_out this cycle.
//  p_out      out  WIDTH  assembled word.
//  bit_cnt    out  CNT_W  bits held in the partial word, 0..WIDTH-1.
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset values: out_valid=0, p_out=0, bit_cnt=0, shift register=0. in_ready=1 after reset.
//  - Bit accept: a bit is taken when in_valid && in_ready at the clk edge.
//    The bit is shifted into the partial word and bit_cnt increments.
//  - Word complete: the accepted bit is the WIDTH-th (bit_cnt==WIDTH-1). At that same edge:
//    - p_out gets the full word, including this bit.
//    - out_valid goes to 1 and bit_cnt goes to 0.
//    - Latency: out_valid is visible in the cycle right after the last bit is accepted.
//  - Output drain: an out_valid && out_ready edge clears out_valid. p_out holds its last value.
//  - Backpressure: in_ready = !(bit_cnt==WIDTH-1 && out_valid && !out_ready).
//    - Only the word-completing bit is ever stalled.
//    - Bits 0..WIDTH-2 are always accepted, even while out_valid is held.
//  - Simultaneous drain and complete: the old word drains and the new word loads at the same edge.
//    out_valid stays 1 and no bubble is inserted.
//  - Gaps: when in_valid=0, the partial word and bit_cnt hold.
//    There is no timeout and no zero-fill.
//  - clear: at the edge, the partial word is discarded and bit_cnt goes to 0.
//    - clear has priority over a bit accepted in the same cycle; that bit is dropped.
//    - out_valid and p_out are not affected.
//    - in_ready is ignored while clear=1 (no accept).
//  - Bit order:
//    - LSB_FIRST=0: shift left, new bit enters at bit 0. The first bit ends in bit WIDTH-1.
//    - LSB_FIRST=1: shift right, new bit enters at bit WIDTH-1. The first bit ends in bit 0.
//  - Reset mid-word or with out_valid=1: everything returns to reset values immediately.
//    The pending word is lost.
//  - Output stability: p_out and out_valid must not change while out_valid && !out_ready.
//  - FSM: implicit, states COLLECT(bit_cnt) x {OUT_EMPTY, OUT_FULL}. No separate state register.
// STRUCTURE
//  - Package sipo_pkg: typedef enum logic {MSB_FIRST=0, LSB_FIRST=1} bit_order_e.
//    Localparam helper for CNT_W.
//  - Single module with three registers: shift reg + bit counter, output word reg, out_valid flag.
//  - No sub-module. The shift/insert logic is one generate branch on LSB_FIRST.
// TESTING
//  1. WIDTH=4, LSB_FIRST=0, out_ready=1, bits 1,0,1,1 back to back ->
//     p_out=4'b1011, out_valid=1 for 1 cycle, one cycle after the 4th bit.
//  2. Same stream with LSB_FIRST=1 -> p_out=4'b1101.
//  3. WIDTH=8, stream 0xA5 MSB-first with in_valid gaps of 3 cycles between bits ->
//     p_out=8'hA5. bit_cnt holds across each gap.
//  4. Backpressure: out_ready=0, send 0x3 then 0xC continuously (WIDTH=4) ->
//     - in_ready drops at the 4th bit of word 2; p_out stays 4'h3.
//     - Raise out_ready -> 4'hC appears the next cycle with no bubble.
//  5. clear after 2 bits of 4'b1100, asserted together with a valid bit ->
//     - bit_cnt=0 and the bit is dropped.
//     - Next 4 bits 0110 give p_out=4'b0110.
//  6. Assert rst_n=0 mid-word and while out_valid=1 ->
//     out_valid, p_out, bit_cnt = 0 asynchronously. Next word assembles correctly.

Source files
------------

// File: rtl/sipo_deser_param_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

    // Bit counter width able to represent 0..w.
    function automatic int unsigned cnt_w_f(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_deser_param.sv
// Serial-in/parallel-out deserializer with selectable bit order and a
// valid/ready output that applies backpressure only to the word-completing bit.
module sipo_deser_param #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b0,
    parameter int unsigned CNT_W     = sipo_pkg::cnt_w_f(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             s_in,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_out,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam sipo_pkg::bit_order_e ORDER    = sipo_pkg::bit_order_e'(LSB_FIRST);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH - 1);

    // Partial word only needs WIDTH-1 bits; the last bit goes straight into p_out.
    logic [WIDTH-2:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_p_out;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_word;
    logic             w_last;
    logic             w_accept;
    logic             w_complete;

    generate
        if (ORDER == sipo_pkg::LSB_FIRST) begin : gen_lsb_first
            assign w_word = {s_in, r_shift};
        end else begin : gen_msb_first
            assign w_word = {r_shift, s_in};
        end
    endgenerate

    assign w_last     = (r_bit_cnt == LAST_CNT);
    assign in_ready   = !(w_last && r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready && !clear;
    assign w_complete = w_accept && w_last;

    // Partial word and bit counter; clear wins over an accepted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (clear) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_complete) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_shift   <= (ORDER == sipo_pkg::LSB_FIRST) ? w_word[WIDTH-1:1] : w_word[WIDTH-2:0];
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    // Output word; holds after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_out <= '0;
        end else if (w_complete) begin
            r_p_out <= w_word;
        end
    end

    // Output valid; a completing word refills in the same edge it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign p_out     = r_p_out;
    assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_sipo_deser_param.sv
// Directed bench for sipo_deser_param: MSB/LSB 4-bit and MSB 8-bit instances share one stimulus.
module tb_sipo_deser_param;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic s_in;
    logic clear;
    logic out_ready;

    logic       m_in_ready, m_out_valid;
    logic [3:0] m_p_out;
    logic [2:0] m_bit_cnt;
    logic       l_in_ready, l_out_valid;
    logic [3:0] l_p_out;
    logic [2:0] l_bit_cnt;
    logic       w_in_ready, w_out_valid;
    logic [7:0] w_p_out;
    logic [3:0] w_bit_cnt;

    int checks = 0;
    int errors = 0;

    sipo_deser_param #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s_in(s_in), .in_ready(m_in_ready),
        .clear(clear), .out_valid(m_out_valid), .out_ready(out_ready), .p_out(m_p_out),
        .bit_cnt(m_bit_cnt)
    );

    sipo_deser_param #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s_in(s_in), .in_ready(l_in_ready),
        .clear(clear), .out_valid(l_out_valid), .out_ready(out_ready), .p_out(l_p_out),
        .bit_cnt(l_bit_cnt)
    );

    sipo_deser_param #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s_in(s_in), .in_ready(w_in_ready),
        .clear(clear), .out_valid(w_out_valid), .out_ready(out_ready), .p_out(w_p_out),
        .bit_cnt(w_bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) begin
            in_valid = 1'b1;
            s_in     = bits[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; s_in = 1'b0; clear = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", m_out_valid); end
        checks++; if (m_p_out !== 4'h0) begin errors++; $display("FAIL reset_p_out got %h exp 0", m_p_out); end
        checks++; if (w_bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bit_cnt got %0d exp 0", w_bit_cnt); end
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", m_in_ready); end
    endtask

    task automatic test_bit_order();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            s_in     = (i == 1) ? 1'b0 : 1'b1;
            tick();
        end
        checks++; if (m_bit_cnt !== 3'd3 || m_out_valid !== 1'b0) begin errors++; $display("FAIL order_pre cnt %0d ov %b exp 3 0", m_bit_cnt, m_out_valid); end
        s_in = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (m_out_valid !== 1'b1 || m_p_out !== 4'b1011) begin errors++; $display("FAIL msb_word ov %b p %b exp 1 1011", m_out_valid, m_p_out); end
        checks++; if (l_out_valid !== 1'b1 || l_p_out !== 4'b1101) begin errors++; $display("FAIL lsb_word ov %b p %b exp 1 1101", l_out_valid, l_p_out); end
        checks++; if (m_bit_cnt !== 3'd0) begin errors++; $display("FAIL msb_cnt_wrap got %0d exp 0", m_bit_cnt); end
        tick();
        checks++; if (m_out_valid !== 1'b0 || m_p_out !== 4'b1011) begin errors++; $display("FAIL msb_drain ov %b p %b exp 0 1011", m_out_valid, m_p_out); end
    endtask

    task automatic test_gaps();
        logic [7:0] word;
        word = 8'hA5;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (w_bit_cnt !== 4'd0) begin errors++; $display("FAIL gap_clear got %0d exp 0", w_bit_cnt); end
        for (int i = 7; i >= 0; i--) begin
            in_valid = 1'b1;
            s_in     = word[i];
            tick();
            in_valid = 1'b0;
            if (i == 0) begin
                checks++; if (w_out_valid !== 1'b1 || w_p_out !== 8'hA5) begin errors++; $display("FAIL gap_word ov %b p %h exp 1 a5", w_out_valid, w_p_out); end
            end
            tick(); tick(); tick();
            checks++; if (w_bit_cnt !== 4'((8 - i) % 8)) begin errors++; $display("FAIL gap_cnt_%0d got %0d exp %0d", 7 - i, w_bit_cnt, (8 - i) % 8); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send4(4'h3);
        checks++; if (m_out_valid !== 1'b1 || m_p_out !== 4'h3) begin errors++; $display("FAIL bp_w1 ov %b p %h exp 1 3", m_out_valid, m_p_out); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            s_in     = (i < 2) ? 1'b1 : 1'b0;
            tick();
        end
        s_in = 1'b0;
        checks++; if (m_bit_cnt !== 3'd3 || m_in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall cnt %0d rdy %b exp 3 0", m_bit_cnt, m_in_ready); end
        tick(); tick();
        checks++; if (m_bit_cnt !== 3'd3 || m_p_out !== 4'h3 || m_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cnt %0d p %h ov %b exp 3 3 1", m_bit_cnt, m_p_out, m_out_valid); end
        out_ready = 1'b1;
        #1;
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b exp 1", m_in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (m_out_valid !== 1'b1 || m_p_out !== 4'hC || m_bit_cnt !== 3'd0) begin errors++; $display("FAIL bp_w2 ov %b p %h cnt %0d exp 1 c 0", m_out_valid, m_p_out, m_bit_cnt); end
        tick();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", m_out_valid); end
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        in_valid = 1'b1; s_in = 1'b1; tick(); tick();
        checks++; if (m_bit_cnt !== 3'd2) begin errors++; $display("FAIL clr_pre got %0d exp 2", m_bit_cnt); end
        clear = 1'b1; s_in = 1'b0;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        checks++; if (m_bit_cnt !== 3'd0 || m_p_out !== 4'hC || m_out_valid !== 1'b0) begin errors++; $display("FAIL clr_cnt cnt %0d p %h ov %b exp 0 c 0", m_bit_cnt, m_p_out, m_out_valid); end
        send4(4'b0110);
        checks++; if (m_out_valid !== 1'b1 || m_p_out !== 4'b0110) begin errors++; $display("FAIL clr_word ov %b p %b exp 1 0110", m_out_valid, m_p_out); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send4(4'hA);
        in_valid = 1'b1; s_in = 1'b1; tick(); tick();
        in_valid = 1'b0;
        checks++; if (m_out_valid !== 1'b1 || m_bit_cnt !== 3'd2) begin errors++; $display("FAIL rst_pre ov %b cnt %0d exp 1 2", m_out_valid, m_bit_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (m_out_valid !== 1'b0 || m_p_out !== 4'h0 || m_bit_cnt !== 3'd0) begin errors++; $display("FAIL rst_async ov %b p %h cnt %0d exp 0 0 0", m_out_valid, m_p_out, m_bit_cnt); end
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send4(4'b0101);
        checks++; if (m_out_valid !== 1'b1 || m_p_out !== 4'b0101) begin errors++; $display("FAIL rst_after ov %b p %b exp 1 0101", m_out_valid, m_p_out); end
        checks++; if (l_p_out !== 4'b1010) begin errors++; $display("FAIL rst_after_lsb got %b exp 1010", l_p_out); end
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_gaps();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
